// File: rtl/instruction_unit.sv
// rtl/instruction_unit.sv - fetch stage: PC/IR, req/ack instruction fetch, next-PC select.
// Optional fetch watchdog enabled by defining IU_FETCH_TIMEOUT_EN.
module instruction_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          TIMEOUT  = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch,
  input  logic        pc_ld,
  input  logic [1:0]  pc_sel,
  input  logic [31:0] jr_addr,
  input  logic [31:0] im_rdata,
  input  logic        im_ack,
  output logic        im_req,
  output logic [31:0] im_addr,
  output logic [31:0] PC_out,
  output logic [31:0] IR_out,
  output logic [31:0] SE_16,
  output logic        fetch_done,
  output logic        busy,
  output logic        fetch_err
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_FETCH = 1'b1
  } state_t;

  localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] addr_q, addr_d;
  logic        done_q, done_d;
  logic [31:0] se_16;
  logic [31:0] target;
  logic [31:0] pc_target;

`ifdef IU_FETCH_TIMEOUT_EN
  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST_WAIT = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
`endif

  assign se_16 = {{16{ir_q[15]}}, ir_q[15:0]};

  // PC already points past the current instruction, so it is the base for every target.
  always_comb begin
    target = pc_q + 32'd4;
    case (pc_sel)
      2'b00:   target = pc_q + 32'd4;
      2'b01:   target = pc_q + {se_16[29:0], 2'b00};
      2'b10:   target = {pc_q[31:28], ir_q[25:0], 2'b00};
      default: target = jr_addr;
    endcase
    pc_target = {target[31:2], 2'b00};
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    addr_d  = addr_q;
    done_d  = 1'b0;
`ifdef IU_FETCH_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (pc_ld) begin
          pc_d = pc_target;
        end
        if (fetch) begin
          addr_d  = pc_ld ? pc_target : pc_q;
          state_d = S_FETCH;
`ifdef IU_FETCH_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      S_FETCH: begin
        if (im_ack) begin
          ir_d    = im_rdata;
          pc_d    = pc_q + 32'd4;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
`ifdef IU_FETCH_TIMEOUT_EN
        else if (cnt_q == LAST_WAIT) begin
          // Abandon the fetch: a NOP goes into IR and PC stays on the faulting word.
          ir_d    = 32'h0000_0000;
          err_d   = 1'b1;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC_ALIGNED;
      ir_q    <= 32'h0000_0000;
      addr_q  <= RESET_PC_ALIGNED;
      done_q  <= 1'b0;
`ifdef IU_FETCH_TIMEOUT_EN
      cnt_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      addr_q  <= addr_d;
      done_q  <= done_d;
`ifdef IU_FETCH_TIMEOUT_EN
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`endif
    end
  end

  assign im_req     = (state_q == S_FETCH);
  assign busy       = (state_q == S_FETCH);
  assign im_addr    = addr_q;
  assign PC_out     = pc_q;
  assign IR_out     = ir_q;
  assign SE_16      = se_16;
  assign fetch_done = done_q;
`ifdef IU_FETCH_TIMEOUT_EN
  assign fetch_err  = err_q;
`else
  // Without the watchdog TIMEOUT has no effect and the error flag never sets.
  assign fetch_err  = 1'b0 && (TIMEOUT > 0);
`endif

endmodule

// File: tb/tb_instruction_unit.sv
// tb/tb_instruction_unit.sv - directed self-checking bench for instruction_unit.
module tb_instruction_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch;
  logic        pc_ld;
  logic [1:0]  pc_sel;
  logic [31:0] jr_addr;
  logic [31:0] im_rdata;
  logic        im_ack;
  logic        im_req;
  logic [31:0] im_addr;
  logic [31:0] PC_out;
  logic [31:0] IR_out;
  logic [31:0] SE_16;
  logic        fetch_done;
  logic        busy;
  logic        fetch_err;

  int n_cmp = 0;
  int n_err = 0;

  instruction_unit #(.RESET_PC(32'h0000_0000), .TIMEOUT(15)) dut (
    .clk(clk), .reset(reset), .fetch(fetch), .pc_ld(pc_ld), .pc_sel(pc_sel),
    .jr_addr(jr_addr), .im_rdata(im_rdata), .im_ack(im_ack), .im_req(im_req),
    .im_addr(im_addr), .PC_out(PC_out), .IR_out(IR_out), .SE_16(SE_16),
    .fetch_done(fetch_done), .busy(busy), .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; fetch = 1'b0; pc_ld = 1'b0; pc_sel = 2'b00;
    jr_addr = 32'h0; im_rdata = 32'h0; im_ack = 1'b0;
    tick();
    tick();
    chk("rst_pc", PC_out, 32'h0);
    chk("rst_ir", IR_out, 32'h0);
    chk("rst_req", {31'b0, im_req}, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_done", {31'b0, fetch_done}, 32'h0);
    chk("rst_err", {31'b0, fetch_err}, 32'h0);
    reset = 1'b0;

    // 1: fetch with ack after 3 cycles
    fetch = 1'b1;
    tick();
    fetch = 1'b0;
    chk("t1_req", {31'b0, im_req}, 32'h1);
    chk("t1_busy", {31'b0, busy}, 32'h1);
    chk("t1_addr", im_addr, 32'h0);
    tick();
    tick();
    chk("t1_wait_req", {31'b0, im_req}, 32'h1);
    chk("t1_wait_pc", PC_out, 32'h0);
    im_ack = 1'b1; im_rdata = 32'h2008_0005;
    tick();
    im_ack = 1'b0;
    chk("t1_ir", IR_out, 32'h2008_0005);
    chk("t1_pc", PC_out, 32'h4);
    chk("t1_done", {31'b0, fetch_done}, 32'h1);
    chk("t1_se16", SE_16, 32'h0000_0005);
    chk("t1_idle_req", {31'b0, im_req}, 32'h0);
    tick();
    chk("t1_done_pulse", {31'b0, fetch_done}, 32'h0);

    // ack while idle is ignored
    im_ack = 1'b1; im_rdata = 32'hDEAD_BEEF;
    tick();
    im_ack = 1'b0;
    chk("idle_ack_ir", IR_out, 32'h2008_0005);
    chk("idle_ack_done", {31'b0, fetch_done}, 32'h0);

    // 2: branch and jump
    fetch = 1'b1;
    tick();
    fetch = 1'b0;
    im_ack = 1'b1; im_rdata = 32'h1000_FFFE;
    tick();
    im_ack = 1'b0;
    chk("t2_pc8", PC_out, 32'h8);
    chk("t2_se16", SE_16, 32'hFFFF_FFFE);
    pc_sel = 2'b01; pc_ld = 1'b1;
    tick();
    pc_ld = 1'b0;
    chk("t2_branch", PC_out, 32'h0);
    fetch = 1'b1;
    tick();
    fetch = 1'b0;
    chk("t2_addr", im_addr, 32'h0);
    im_ack = 1'b1; im_rdata = 32'h0800_0010;
    tick();
    im_ack = 1'b0;
    chk("t2_pc4", PC_out, 32'h4);
    pc_sel = 2'b10; pc_ld = 1'b1;
    tick();
    pc_ld = 1'b0;
    chk("t2_jump", PC_out, 32'h0000_0040);

    // 3: jump register, alignment, same-cycle load+fetch
    pc_sel = 2'b11; jr_addr = 32'h0000_1237; pc_ld = 1'b1;
    tick();
    pc_ld = 1'b0;
    chk("t3_jr", PC_out, 32'h0000_1234);
    jr_addr = 32'h0000_5679; pc_ld = 1'b1; fetch = 1'b1;
    tick();
    pc_ld = 1'b0; fetch = 1'b0;
    chk("t3_ld_pc", PC_out, 32'h0000_5678);
    chk("t3_ld_addr", im_addr, 32'h0000_5678);
    im_ack = 1'b1; im_rdata = 32'h0;
    tick();
    im_ack = 1'b0;
    chk("t3_pc_after", PC_out, 32'h0000_567C);
    chk("t3_addr_hold", im_addr, 32'h0000_5678);
    pc_sel = 2'b00; pc_ld = 1'b1;
    tick();
    pc_ld = 1'b0;
    chk("t3_seq", PC_out, 32'h0000_5680);

    // 4: wrap, and pc_ld/fetch ignored during FETCH
    pc_sel = 2'b11; jr_addr = 32'hFFFF_FFFC; pc_ld = 1'b1;
    tick();
    pc_ld = 1'b0;
    chk("t4_top", PC_out, 32'hFFFF_FFFC);
    fetch = 1'b1;
    tick();
    jr_addr = 32'h0000_0100; pc_ld = 1'b1; fetch = 1'b1;
    tick();
    pc_ld = 1'b0; fetch = 1'b0;
    chk("t4_ign_pc", PC_out, 32'hFFFF_FFFC);
    chk("t4_ign_addr", im_addr, 32'hFFFF_FFFC);
    chk("t4_req", {31'b0, im_req}, 32'h1);
    im_ack = 1'b1; im_rdata = 32'h1111_2222;
    tick();
    im_ack = 1'b0;
    chk("t4_wrap", PC_out, 32'h0);
    chk("t4_ir", IR_out, 32'h1111_2222);
    chk("t4_single_req", {31'b0, im_req}, 32'h0);
    tick();
    chk("t4_no_queue", {31'b0, busy}, 32'h0);

    // 5: reset in the middle of a fetch
    pc_sel = 2'b11; jr_addr = 32'h0000_0300; pc_ld = 1'b1;
    tick();
    pc_ld = 1'b0;
    fetch = 1'b1;
    tick();
    fetch = 1'b0;
    chk("t5_req", {31'b0, im_req}, 32'h1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t5_req_drop", {31'b0, im_req}, 32'h0);
    chk("t5_pc", PC_out, 32'h0);
    chk("t5_ir", IR_out, 32'h0);
    im_ack = 1'b1; im_rdata = 32'hCAFE_F00D;
    tick();
    im_ack = 1'b0;
    chk("t5_late_ack_ir", IR_out, 32'h0);
    chk("t5_late_ack_pc", PC_out, 32'h0);

    // 6: no ack at all
    fetch = 1'b1;
    tick();
    fetch = 1'b0;
    im_ack = 1'b1; im_rdata = 32'hABCD_0001;
    tick();
    im_ack = 1'b0;
    chk("t6_ir", IR_out, 32'hABCD_0001);
    chk("t6_pc", PC_out, 32'h4);
    fetch = 1'b1;
    tick();
    fetch = 1'b0;
`ifdef IU_FETCH_TIMEOUT_EN
    for (int i = 0; i < 14; i++) tick();
    chk("t6_still_busy", {31'b0, busy}, 32'h1);
    chk("t6_no_err_yet", {31'b0, fetch_err}, 32'h0);
    tick();
    chk("t6_to_ir", IR_out, 32'h0);
    chk("t6_to_pc", PC_out, 32'h4);
    chk("t6_to_err", {31'b0, fetch_err}, 32'h1);
    chk("t6_to_done", {31'b0, fetch_done}, 32'h1);
    chk("t6_to_idle", {31'b0, busy}, 32'h0);
    tick();
    chk("t6_err_sticky", {31'b0, fetch_err}, 32'h1);
`else
    for (int i = 0; i < 100; i++) tick();
    chk("t6_busy_100", {31'b0, busy}, 32'h1);
    chk("t6_err_0", {31'b0, fetch_err}, 32'h0);
    chk("t6_pc_hold", PC_out, 32'h4);
`endif
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("end_err_clr", {31'b0, fetch_err}, 32'h0);
    chk("end_idle", {31'b0, busy}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
